// File: rtl/gate_pkg.sv
// Shared types and the round-robin pick function for the gate arbiter.
package gate_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_GAP} gate_arb_st_t;

    localparam int STAT_W  = 16;
    localparam int MAX_REQ = 8;

    // Requests above N_REQ are zero-padded, so searching over all MAX_REQ
    // slots wraps exactly like a search over N_REQ slots.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                   input logic [2:0]         ptr);
        logic [MAX_REQ-1:0] pick;
        logic [2:0]         idx;
        pick = '0;
        // Farthest candidate first; the nearest one after ptr overwrites last.
        for (int i = MAX_REQ; i >= 1; i--) begin
            idx = ptr + 3'(i);
            if (req[idx]) begin
                pick      = '0;
                pick[idx] = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/gate_rr_arbiter.sv
// Combinational round-robin picker: first set request after ptr, with wrap.
module gate_rr_arbiter
    import gate_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [PW-1:0]    idx
);

    logic [MAX_REQ-1:0] w_req_ext;
    logic [MAX_REQ-1:0] w_pick;
    logic [2:0]         w_ptr_ext;
    logic               w_unused_pick;

    always_comb begin
        w_req_ext              = '0;
        w_req_ext[N_REQ-1:0]   = req;
        w_ptr_ext              = '0;
        w_ptr_ext[PW-1:0]      = ptr;
    end

    assign w_pick        = rr_pick(w_req_ext, w_ptr_ext);
    assign gnt           = w_pick[N_REQ-1:0];
    assign w_unused_pick = ^w_pick;

    always_comb begin
        idx = '0;
        for (int i = 0; i < N_REQ; i++)
            if (w_pick[i]) idx = PW'(i);
    end

endmodule

// File: rtl/gate_arbiter.sv
// Round-robin arbiter feeding the gated receive datapath with sig/priem/inp.
// Optional GATE_ARB_STATS_EN adds per-requester saturating grant counters.
module gate_arbiter
    import gate_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DW         = 8,
    parameter int WINDOW     = 6,
    parameter int CURSOR_DLY = 3,
    parameter int GAP        = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*DW-1:0]    data_in,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    output logic                   sig,
    output logic                   priem,
    output logic [DW-1:0]          inp,
    output logic                   right_cursor,
    output logic                   busy
`ifdef GATE_ARB_STATS_EN
    ,
    output logic [N_REQ*STAT_W-1:0] grant_cnt
`endif
);

    localparam int CW = $clog2(WINDOW + 1);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    if (N_REQ < 2 || N_REQ > MAX_REQ) begin : g_bad_nreq
        $error("gate_arbiter: N_REQ must be 2..8");
    end
    if (DW < 1) begin : g_bad_dw
        $error("gate_arbiter: DW must be >= 1");
    end
    if (WINDOW < 2) begin : g_bad_window
        $error("gate_arbiter: WINDOW must be >= 2");
    end
    if (CURSOR_DLY < 1 || CURSOR_DLY > WINDOW - 1) begin : g_bad_cursor
        $error("gate_arbiter: CURSOR_DLY must be 1..WINDOW-1");
    end
    if (GAP < 0 || GAP > 15) begin : g_bad_gap
        $error("gate_arbiter: GAP must be 0..15");
    end

    gate_arb_st_t      r_state;
    logic [CW-1:0]     r_cnt;
    logic [3:0]        r_gap;
    logic [PW-1:0]     r_ptr;
    logic [N_REQ-1:0]  r_gnt;
    logic [N_REQ-1:0]  r_done;
    logic              r_sig;
    logic              r_priem;
    logic              r_rc;
    logic [DW-1:0]     r_inp;

    logic [N_REQ-1:0]  w_rr_gnt;
    logic [PW-1:0]     w_rr_idx;
    logic [DW-1:0]     w_sel;
    logic [CW-1:0]     w_cnt_nxt;

    gate_rr_arbiter #(.N_REQ(N_REQ), .PW(PW)) u_rr (
        .req (req),
        .ptr (r_ptr),
        .gnt (w_rr_gnt),
        .idx (w_rr_idx)
    );

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < N_REQ; i++)
            if (w_rr_gnt[i]) w_sel = data_in[i*DW +: DW];
    end

    assign w_cnt_nxt = r_cnt + 1'b1;

    // Strobes are registered one cycle ahead off w_cnt_nxt so they line up
    // with the cnt value they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_gap   <= '0;
            r_ptr   <= PW'(N_REQ - 1);
            r_gnt   <= '0;
            r_done  <= '0;
            r_sig   <= 1'b0;
            r_priem <= 1'b0;
            r_rc    <= 1'b0;
            r_inp   <= '0;
        end else begin
            r_priem <= 1'b0;
            r_rc    <= 1'b0;
            r_done  <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (|req) begin
                        r_gnt   <= w_rr_gnt;
                        r_inp   <= w_sel;
                        r_sig   <= 1'b1;
                        r_priem <= 1'b1;
                        r_cnt   <= '0;
                        r_ptr   <= w_rr_idx;
                        r_state <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (r_cnt == CW'(WINDOW - 1)) begin
                        r_sig   <= 1'b0;
                        r_gnt   <= '0;
                        r_inp   <= '0;
                        r_cnt   <= '0;
                        r_gap   <= '0;
                        r_state <= (GAP > 0) ? ST_GAP : ST_IDLE;
                    end else begin
                        r_cnt  <= w_cnt_nxt;
                        r_rc   <= (w_cnt_nxt == CW'(CURSOR_DLY));
                        r_done <= (w_cnt_nxt == CW'(WINDOW - 1)) ? r_gnt : '0;
                    end
                end
                ST_GAP: begin
                    if (r_gap == 4'(GAP - 1)) r_state <= ST_IDLE;
                    else                      r_gap   <= r_gap + 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign gnt          = r_gnt;
    assign done         = r_done;
    assign sig          = r_sig;
    assign priem        = r_priem;
    assign inp          = r_inp;
    assign right_cursor = r_rc;
    assign busy         = (r_state != ST_IDLE);

`ifdef GATE_ARB_STATS_EN
    for (genvar i = 0; i < N_REQ; i++) begin : g_stat
        logic [STAT_W-1:0] r_stat;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                        r_stat <= '0;
            else if (r_done[i] && r_stat != '1) r_stat <= r_stat + 1'b1;
        end
        assign grant_cnt[i*STAT_W +: STAT_W] = r_stat;
    end
`endif

endmodule

// File: tb/tb_gate_arbiter.sv
// Scoreboard bench for gate_arbiter: stimulus queues expected windows, a
// negedge monitor checks every window cycle-by-cycle against them.
module tb_gate_arbiter;

    localparam int N  = 4;
    localparam int W  = 6;
    localparam int CD = 3;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*8-1:0] data_in;
    logic [N-1:0]   gnt, done;
    logic           sig, priem, right_cursor, busy;
    logic [7:0]     inp;
`ifdef GATE_ARB_STATS_EN
    logic [N*16-1:0] grant_cnt;
`endif

    gate_arbiter #(.N_REQ(N), .DW(8), .WINDOW(W), .CURSOR_DLY(CD), .GAP(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .data_in      (data_in),
        .gnt          (gnt),
        .done         (done),
        .sig          (sig),
        .priem        (priem),
        .inp          (inp),
        .right_cursor (right_cursor),
        .busy         (busy)
`ifdef GATE_ARB_STATS_EN
        ,
        .grant_cnt    (grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] gnt;
        logic [7:0]   inp;
        int           gap;   // expected sig-low cycles before this window, -1 = don't care
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor
    bit   mon_act  = 0;
    int   mon_c    = 0;
    int   cyc      = 0;
    int   last_end = 0;
    exp_t cur;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            mon_act = 0;
        end else begin
            if (priem) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_window: gnt %0h with empty scoreboard", gnt);
                end else begin
                    cur = q.pop_front();
                    if (cur.gap >= 0) chk("win_gap", cyc - last_end - 1, cur.gap);
                    mon_act = 1;
                    mon_c   = 0;
                end
            end
            if (mon_act) begin
                chk("win_sig",   sig, 1);
                chk("win_busy",  busy, 1);
                chk("win_gnt",   gnt, cur.gnt);
                chk("win_inp",   inp, cur.inp);
                chk("win_priem", priem, (mon_c == 0));
                chk("win_rc",    right_cursor, (mon_c == CD));
                chk("win_done",  done, (mon_c == W - 1) ? cur.gnt : '0);
                mon_c++;
                if (mon_c == W) begin
                    mon_act  = 0;
                    last_end = cyc;
                end
            end else if (!priem) begin
                chk("idle_outs", {sig, right_cursor, priem, done, gnt, inp}, 0);
            end
        end
    end

    // which: 0 = priem, 1 = any done, 2 = not busy
    task automatic wait_ev(input int which);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if ((which == 0 && priem) || (which == 1 && |done) || (which == 2 && !busy))
                return;
        end
        n_chk++;
        n_err++;
        $display("FAIL wait_timeout: event %0d never seen, expected within 200 cycles", which);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset with every request raised
        rst_n   = 1'b0;
        req     = '1;
        data_in = {8'h44, 8'h33, 8'h22, 8'h11};
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outs", {sig, right_cursor, priem, done, gnt, inp}, 0);
        chk("rst_busy", busy, 0);
        q.push_back('{4'b0001, 8'h11, -1});
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_first_gnt", gnt, 4'b0001);
        req = '0;
        wait_ev(2);

        // Single requester, full window shape
        data_in = {8'h44, 8'hA5, 8'h22, 8'h11};
        q.push_back('{4'b0100, 8'hA5, -1});
        req = 4'b0100;
        wait_ev(1);
        req = '0;
        wait_ev(2);

        // All requesters held: 0,1,2,3,0 with 2-cycle spacing
        do_reset();
        data_in = {8'h44, 8'h33, 8'h22, 8'h11};
        q.push_back('{4'b0001, 8'h11, -1});
        q.push_back('{4'b0010, 8'h22, 2});
        q.push_back('{4'b0100, 8'h33, 2});
        q.push_back('{4'b1000, 8'h44, 2});
        q.push_back('{4'b0001, 8'h11, 2});
        req = 4'b1111;
        repeat (5) wait_ev(1);
        req = '0;
        wait_ev(2);

        // req dropped and data changed mid-window
        q.push_back('{4'b0010, 8'h22, -1});
        req = 4'b0010;
        wait_ev(0);
        repeat (2) @(posedge clk);
        #1;
        req     = '0;
        data_in = {8'h55, 8'h66, 8'h99, 8'h77};
        wait_ev(2);
        data_in = {8'h44, 8'h33, 8'h22, 8'h11};

        // Reset in window cycle 3; pointer must return to N-1
        do_reset();
        q.push_back('{4'b0010, 8'h22, -1});
        q.push_back('{4'b0010, 8'h22, -1});
        req = 4'b0110;
        wait_ev(0);
        repeat (CD) @(posedge clk);
        #1;
        chk("mid_rc", right_cursor, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", {sig, right_cursor, priem, done, gnt, inp}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_ev(0);
        req = '0;
        wait_ev(2);
        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", q.size(), 0);
        chk("mon_idle", mon_act, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
